l1d_tag_checker: RTL and testbench
==================================

Name: l1d_tag_checker

Overview:
- L1D tag-lookup stage; drives the read and write ports of the L1D tag SRAM wrapper and consumes its read data.
- Accepts probes of (set, tag), issues tag reads, and compares all ways one cycle later.
- Returns hit/way, or a replacement victim (first invalid way, else per-set round-robin), through a 2-entry result FIFO.
- Also performs allocation writes and a full-array invalidate sweep.

Parameters:
- TAG_WIDTH, 20, tag bits per way; the SRAM entry per way is GEN_WIDTH = TAG_WIDTH+1 bits, {valid, tag}, with valid at the MSB.
- NUM_SET, 32, sets.
- NUM_WAY, 2, ways (>=1).
- SET_DEPTH, 5, log2(NUM_SET).
- WAY_DEPTH, 1, max(1, log2(NUM_WAY)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- probe_valid_i / probe_ready_o  in/out  1/1  probe handshake.
- probe_setid_i  in  SET_DEPTH  probe set.
- probe_tag_i  in  TAG_WIDTH  probe tag.
- result_valid_o / result_ready_i  out/in  1/1  result handshake (FIFO head).
- result_hit_o  out  1  hit.
- result_way_o  out  WAY_DEPTH  hit way if hit, else victim way.
- result_victim_valid_o  out  1  miss and victim way currently valid (eviction needed).
- result_victim_tag_o  out  TAG_WIDTH  tag of victim way (0 on hit).
- alloc_valid_i / alloc_ready_o  in/out  1/1  allocation handshake.
- alloc_setid_i  in  SET_DEPTH  allocation set.
- alloc_way_i  in  WAY_DEPTH  allocation way.
- alloc_tag_i  in  TAG_WIDTH  allocation tag.
- flush_req_i  in  1  invalidate-all request (level, sampled in IDLE).
- flush_done_o  out  1  one-cycle pulse when a sweep ends.
- tag_r_req_valid_o / tag_r_req_setid_o  out  1/SET_DEPTH  SRAM read request.
- tag_r_resp_data_i  in  NUM_WAY*GEN_WIDTH  SRAM read data, valid the cycle after the request; way k at bits [k*GEN_WIDTH +: GEN_WIDTH].
- tag_w_req_valid_o / tag_w_req_setid_o / tag_w_req_waymask_o / tag_w_req_data_o  out  1/SET_DEPTH/NUM_WAY/NUM_WAY*GEN_WIDTH  SRAM write request.

Behaviour:
- Reset values:
  - FSM = FLUSH, sweep counter 0, all rr_ptr 0, s1_valid 0, FIFO empty.
  - All valid/ready/done outputs 0; data outputs 0.
- FSM states: IDLE, DRAIN, FLUSH.
  - IDLE -> DRAIN when flush_req_i=1.
  - DRAIN -> FLUSH when s1_valid=0 (DRAIN may be left in the same cycle it is entered if s1 is empty).
  - FLUSH: write set = counter, waymask all ones, data 0, one set per cycle. Counter increments each cycle. After writing set NUM_SET-1: go to IDLE, pulse flush_done_o in the following cycle, clear all rr_ptr.
  - Reset therefore performs one full sweep (NUM_SET cycles) before the first probe is accepted.
- Probe path:
  - probe_ready_o = (state==IDLE) && (fifo_count + s1_valid < 2).
  - On accept, tag_r_req_valid_o=1 and tag_r_req_setid_o=probe_setid_i in the same cycle (combinational). s1 registers set and tag.
  - Next cycle (s1_valid): compare each way using merged data. Merged data = tag_r_resp_data_i with any same-set tag write issued in this same cycle overlaid per waymask. The SRAM bypasses only writes that coincide with the read cycle, so this merge covers the following cycle.
  - Hit = valid && tag match in any way. Multiple matches: lowest way index.
  - Miss: victim = lowest-index invalid way; if all are valid, victim = rr_ptr[set]. victim_valid / victim_tag come from the merged data.
  - The result is pushed into the FIFO at the end of the s1 cycle. Pushing never fails, by the credit rule above.
  - Probe-to-result_valid latency = 2 cycles with the FIFO empty. Throughput is 1 per cycle while result_ready_i=1.
- FIFO:
  - Depth 2, first-word-fall-through; outputs are driven from the head entry.
  - Simultaneous push and pop is allowed.
  - Entries already queued are not updated by later allocs or flushes; keeping them coherent is the consumer's responsibility.
- Alloc path:
  - alloc_ready_o = (state==IDLE); in DRAIN and FLUSH allocs are held off.
  - On accept: write set alloc_setid_i, waymask one-hot(alloc_way_i), data {1'b1, alloc_tag_i} replicated to every way lane.
  - rr_ptr[set] <= (alloc_way_i==NUM_WAY-1) ? 0 : alloc_way_i+1.
  - A probe and an alloc may both be accepted in one cycle. A same-set read/write collision in that cycle returns the new data via the SRAM wrapper's bypass.
- Only one write source is active per cycle (FLUSH sweep or alloc, never both); tag_w_req_valid_o is combinational from the accepted source.
- Reset mid-sweep or mid-probe: all state returns to reset values and the sweep restarts at set 0. No result is produced for in-flight probes.

Test Plan:
- Release reset. Hold probe_valid_i=1 from cycle 0. -> probe_ready_o=0 for 32 cycles; tag writes to sets 0..31 with data 0; flush_done_o pulses once; first probe is accepted after the sweep.
- Alloc set 3, way 1, tag 0xABCDE; two cycles later probe set 3, tag 0xABCDE. -> hit=1, way=1.
- Probe set 3, tag 0x12345 with way 0 invalid. -> hit=0, way=0, victim_valid=0.
- Alloc set 5 ways 0 and 1 (tags 0x1, 0x2), then alloc set 5 way 0 (tag 0x3), so rr_ptr[5]=1. Probe set 5, tag 0x9. -> miss, way=1, victim_valid=1, victim_tag=0x2.
- Probe set 7 in cycle t; alloc set 7 way 0 tag 0x77 in cycle t+1; probe tag 0x77. -> hit=1 via the compare-stage merge.
- Hold result_ready_i=0 and stream probes. -> exactly 2 accepted, probe_ready_o stays 0. Release ready. -> results pop in order with no loss, then probe_ready_o returns to 1.

Source files
------------

// File: rtl/l1d_tag_checker.sv
// L1D tag-lookup stage: probe -> SRAM tag read -> way compare -> 2-entry result FIFO.
// Also owns allocation writes, per-set round-robin victim pointers and the invalidate sweep.
module l1d_tag_checker #(
    parameter int unsigned TAG_WIDTH = 20,
    parameter int unsigned NUM_SET   = 32,
    parameter int unsigned NUM_WAY   = 2,
    parameter int unsigned SET_DEPTH = 5,
    parameter int unsigned WAY_DEPTH = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             probe_valid_i,
    output logic                             probe_ready_o,
    input  logic [SET_DEPTH-1:0]             probe_setid_i,
    input  logic [TAG_WIDTH-1:0]             probe_tag_i,
    output logic                             result_valid_o,
    input  logic                             result_ready_i,
    output logic                             result_hit_o,
    output logic [WAY_DEPTH-1:0]             result_way_o,
    output logic                             result_victim_valid_o,
    output logic [TAG_WIDTH-1:0]             result_victim_tag_o,
    input  logic                             alloc_valid_i,
    output logic                             alloc_ready_o,
    input  logic [SET_DEPTH-1:0]             alloc_setid_i,
    input  logic [WAY_DEPTH-1:0]             alloc_way_i,
    input  logic [TAG_WIDTH-1:0]             alloc_tag_i,
    input  logic                             flush_req_i,
    output logic                             flush_done_o,
    output logic                             tag_r_req_valid_o,
    output logic [SET_DEPTH-1:0]             tag_r_req_setid_o,
    input  logic [NUM_WAY*(TAG_WIDTH+1)-1:0] tag_r_resp_data_i,
    output logic                             tag_w_req_valid_o,
    output logic [SET_DEPTH-1:0]             tag_w_req_setid_o,
    output logic [NUM_WAY-1:0]               tag_w_req_waymask_o,
    output logic [NUM_WAY*(TAG_WIDTH+1)-1:0] tag_w_req_data_o
);

    localparam int unsigned GEN_WIDTH = TAG_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StDrain, StFlush} state_e;

    typedef struct packed {
        logic                 hit;
        logic [WAY_DEPTH-1:0] way;
        logic                 victim_valid;
        logic [TAG_WIDTH-1:0] victim_tag;
    } result_t;

    state_e               state_q, state_d;
    logic [SET_DEPTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 flush_done_q, flush_done_d;
    logic [WAY_DEPTH-1:0] rr_ptr_q [NUM_SET];

    logic                 s1_valid_q;
    logic [SET_DEPTH-1:0] s1_set_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;

    result_t              fifo_q [2];
    logic                 fifo_wr_q, fifo_rd_q;
    logic [1:0]           fifo_cnt_q;

    logic                 probe_fire, alloc_fire, flush_active;
    logic                 fifo_push, fifo_pop;
    logic [GEN_WIDTH-1:0] merged [NUM_WAY];
    logic                 hit;
    logic [WAY_DEPTH-1:0] hit_way, inv_way, victim_way;
    logic                 inv_found;
    result_t              s1_res;

    assign probe_ready_o = (state_q == StIdle) &&
                           (({1'b0, fifo_cnt_q} + {2'b00, s1_valid_q}) < 3'd2);
    assign alloc_ready_o = (state_q == StIdle);
    assign probe_fire    = probe_valid_i && probe_ready_o;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    // Sweep writes are withheld while reset is still asserted.
    assign flush_active  = (state_q == StFlush) && rst_n;

    assign tag_r_req_valid_o = probe_fire;
    assign tag_r_req_setid_o = probe_fire ? probe_setid_i : '0;
    assign flush_done_o      = flush_done_q;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            StIdle:  if (flush_req_i) state_d = StDrain;
            StDrain: if (!s1_valid_q) state_d = StFlush;
            StFlush: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == SET_DEPTH'(NUM_SET - 1)) begin
                    state_d      = StIdle;
                    flush_cnt_d  = '0;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = StFlush;
        endcase
    end

    always_comb begin
        tag_w_req_valid_o   = 1'b0;
        tag_w_req_setid_o   = '0;
        tag_w_req_waymask_o = '0;
        tag_w_req_data_o    = '0;
        if (flush_active) begin
            tag_w_req_valid_o   = 1'b1;
            tag_w_req_setid_o   = flush_cnt_q;
            tag_w_req_waymask_o = '1;
        end else if (alloc_fire) begin
            tag_w_req_valid_o   = 1'b1;
            tag_w_req_setid_o   = alloc_setid_i;
            tag_w_req_waymask_o = NUM_WAY'(1) << alloc_way_i;
            tag_w_req_data_o    = {NUM_WAY{{1'b1, alloc_tag_i}}};
        end
    end

    // The SRAM only bypasses writes coincident with the read, so overlay this cycle's write.
    always_comb begin
        for (int k = 0; k < NUM_WAY; k++) begin
            merged[k] = tag_r_resp_data_i[k*GEN_WIDTH +: GEN_WIDTH];
            if (tag_w_req_valid_o && (tag_w_req_setid_o == s1_set_q) &&
                tag_w_req_waymask_o[k]) begin
                merged[k] = tag_w_req_data_o[k*GEN_WIDTH +: GEN_WIDTH];
            end
        end
    end

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int k = 0; k < NUM_WAY; k++) begin
            if (!hit && merged[k][GEN_WIDTH-1] && (merged[k][TAG_WIDTH-1:0] == s1_tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_DEPTH'(k);
            end
            if (!inv_found && !merged[k][GEN_WIDTH-1]) begin
                inv_found = 1'b1;
                inv_way   = WAY_DEPTH'(k);
            end
        end
        victim_way          = inv_found ? inv_way : rr_ptr_q[s1_set_q];
        s1_res.hit          = hit;
        s1_res.way          = hit ? hit_way : victim_way;
        s1_res.victim_valid = !hit && merged[victim_way][GEN_WIDTH-1];
        s1_res.victim_tag   = hit ? '0 : merged[victim_way][TAG_WIDTH-1:0];
    end

    assign fifo_push = s1_valid_q;
    assign fifo_pop  = (fifo_cnt_q != 2'd0) && result_ready_i;

    assign result_valid_o        = (fifo_cnt_q != 2'd0);
    assign result_hit_o          = fifo_q[fifo_rd_q].hit;
    assign result_way_o          = fifo_q[fifo_rd_q].way;
    assign result_victim_valid_o = fifo_q[fifo_rd_q].victim_valid;
    assign result_victim_tag_o   = fifo_q[fifo_rd_q].victim_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFlush;
            flush_cnt_q  <= '0;
            flush_done_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_set_q     <= '0;
            s1_tag_q     <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            flush_done_q <= flush_done_d;
            s1_valid_q   <= probe_fire;
            if (probe_fire) begin
                s1_set_q <= probe_setid_i;
                s1_tag_q <= probe_tag_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SET; s++) rr_ptr_q[s] <= '0;
        end else if (flush_done_d) begin
            for (int s = 0; s < NUM_SET; s++) rr_ptr_q[s] <= '0;
        end else if (alloc_fire) begin
            rr_ptr_q[alloc_setid_i] <= (alloc_way_i == WAY_DEPTH'(NUM_WAY - 1)) ? '0 :
                                       alloc_way_i + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_q[fifo_wr_q] <= s1_res;
                fifo_wr_q         <= ~fifo_wr_q;
            end
            if (fifo_pop) fifo_rd_q <= ~fifo_rd_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

endmodule

// File: tb/tb_l1d_tag_checker.sv
// Scoreboard bench for l1d_tag_checker with a behavioural tag SRAM (read-cycle write bypass).
module tb_l1d_tag_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        probe_valid_i = 1'b0, probe_ready_o;
    logic [4:0]  probe_setid_i = '0;
    logic [19:0] probe_tag_i = '0;
    logic        result_valid_o, result_ready_i = 1'b1;
    logic        result_hit_o;
    logic        result_way_o;
    logic        result_victim_valid_o;
    logic [19:0] result_victim_tag_o;
    logic        alloc_valid_i = 1'b0, alloc_ready_o;
    logic [4:0]  alloc_setid_i = '0;
    logic        alloc_way_i = 1'b0;
    logic [19:0] alloc_tag_i = '0;
    logic        flush_req_i = 1'b0, flush_done_o;
    logic        tag_r_req_valid_o;
    logic [4:0]  tag_r_req_setid_o;
    logic [41:0] tag_r_resp_data_i = '0;
    logic        tag_w_req_valid_o;
    logic [4:0]  tag_w_req_setid_o;
    logic [1:0]  tag_w_req_waymask_o;
    logic [41:0] tag_w_req_data_o;

    l1d_tag_checker dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .probe_valid_i         (probe_valid_i),
        .probe_ready_o         (probe_ready_o),
        .probe_setid_i         (probe_setid_i),
        .probe_tag_i           (probe_tag_i),
        .result_valid_o        (result_valid_o),
        .result_ready_i        (result_ready_i),
        .result_hit_o          (result_hit_o),
        .result_way_o          (result_way_o),
        .result_victim_valid_o (result_victim_valid_o),
        .result_victim_tag_o   (result_victim_tag_o),
        .alloc_valid_i         (alloc_valid_i),
        .alloc_ready_o         (alloc_ready_o),
        .alloc_setid_i         (alloc_setid_i),
        .alloc_way_i           (alloc_way_i),
        .alloc_tag_i           (alloc_tag_i),
        .flush_req_i           (flush_req_i),
        .flush_done_o          (flush_done_o),
        .tag_r_req_valid_o     (tag_r_req_valid_o),
        .tag_r_req_setid_o     (tag_r_req_setid_o),
        .tag_r_resp_data_i     (tag_r_resp_data_i),
        .tag_w_req_valid_o     (tag_w_req_valid_o),
        .tag_w_req_setid_o     (tag_w_req_setid_o),
        .tag_w_req_waymask_o   (tag_w_req_waymask_o),
        .tag_w_req_data_o      (tag_w_req_data_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic        way;
        logic        vv;
        logic [19:0] vtag;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_fail = 0;
    int          flush_wr_cnt = 0;
    int          flush_done_cnt = 0;
    logic [31:0] flush_seen = '0;
    logic [41:0] mem [32];
    logic [41:0] rd_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Stale valid entries everywhere, so a missing sweep shows up as false hits.
    initial for (int s = 0; s < 32; s++) mem[s] = {2{{1'b1, 20'(s)}}};

    always @(posedge clk) begin
        if (tag_r_req_valid_o) begin
            rd_word = mem[tag_r_req_setid_o];
            if (tag_w_req_valid_o && tag_w_req_setid_o == tag_r_req_setid_o)
                for (int k = 0; k < 2; k++)
                    if (tag_w_req_waymask_o[k]) rd_word[k*21 +: 21] = tag_w_req_data_o[k*21 +: 21];
            tag_r_resp_data_i <= rd_word;
        end
        if (tag_w_req_valid_o)
            for (int k = 0; k < 2; k++)
                if (tag_w_req_waymask_o[k])
                    mem[tag_w_req_setid_o][k*21 +: 21] <= tag_w_req_data_o[k*21 +: 21];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (tag_w_req_valid_o && tag_w_req_waymask_o == 2'b11 && tag_w_req_data_o == '0) begin
                flush_wr_cnt++;
                flush_seen[tag_w_req_setid_o] = 1'b1;
            end
            if (flush_done_o) flush_done_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && result_valid_o && result_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hit", 32'(result_hit_o), 32'(mon_e.hit));
                check("result_way", 32'(result_way_o), 32'(mon_e.way));
                check("result_victim_valid", 32'(result_victim_valid_o), 32'(mon_e.vv));
                check("result_victim_tag", 32'(result_victim_tag_o), 32'(mon_e.vtag));
            end
        end
    end

    task automatic probe(input logic [4:0] set, input logic [19:0] tag, input logic hit,
                         input logic way, input logic vv, input logic [19:0] vtag);
        logic done = 1'b0;
        @(posedge clk); #1;
        probe_valid_i = 1'b1;
        probe_setid_i = set;
        probe_tag_i   = tag;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (probe_ready_o) begin
                exp_q.push_back('{hit, way, vv, vtag});
                done = 1'b1;
            end
        end
        if (!done) check("probe_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        probe_valid_i = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] set, input logic way, input logic [19:0] tag);
        logic done = 1'b0;
        @(posedge clk); #1;
        alloc_valid_i = 1'b1;
        alloc_setid_i = set;
        alloc_way_i   = way;
        alloc_tag_i   = tag;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (alloc_ready_o) done = 1'b1;
        end
        if (!done) check("alloc_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        alloc_valid_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    exp_t        stream_exp [4];
    logic [4:0]  stream_set [4];
    logic [19:0] stream_tag [4];

    initial begin
        int ready_low = 0;
        int n_acc = 0;
        logic seen_ready = 1'b0;

        // Reset state, with a probe already pending.
        probe_valid_i = 1'b1;
        probe_setid_i = 5'd0;
        probe_tag_i   = 20'h0;
        repeat (3) @(negedge clk);
        check("rst_probe_ready", 32'(probe_ready_o), 32'd0);
        check("rst_tag_w_valid", 32'(tag_w_req_valid_o), 32'd0);
        check("rst_tag_r_valid", 32'(tag_r_req_valid_o), 32'd0);
        check("rst_result_valid", 32'(result_valid_o), 32'd0);
        check("rst_flush_done", 32'(flush_done_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 100 && !seen_ready; i++) begin
            @(negedge clk);
            if (probe_ready_o) begin
                seen_ready = 1'b1;
                exp_q.push_back('{1'b0, 1'b0, 1'b0, 20'h0});
            end else begin
                ready_low++;
            end
        end
        check("sweep_ready_low_cycles", 32'(ready_low), 32'd32);
        @(posedge clk); #1;
        probe_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("sweep_write_count", 32'(flush_wr_cnt), 32'd32);
        check("sweep_sets_covered", flush_seen, 32'hFFFF_FFFF);
        check("sweep_done_pulses", 32'(flush_done_cnt), 32'd1);

        // Hit after alloc; miss onto an invalid way.
        alloc(5'd3, 1'b1, 20'hABCDE);
        @(posedge clk);
        probe(5'd3, 20'hABCDE, 1'b1, 1'b1, 1'b0, 20'h0);
        probe(5'd3, 20'h12345, 1'b0, 1'b0, 1'b0, 20'h0);

        // Round-robin victim with both ways valid.
        alloc(5'd5, 1'b0, 20'h1);
        alloc(5'd5, 1'b1, 20'h2);
        alloc(5'd5, 1'b0, 20'h3);
        probe(5'd5, 20'h9, 1'b0, 1'b1, 1'b1, 20'h2);
        alloc(5'd11, 1'b0, 20'hA);
        alloc(5'd11, 1'b1, 20'hB);
        probe(5'd11, 20'hC, 1'b0, 1'b0, 1'b1, 20'hA);

        // Alloc lands in the compare cycle of a same-set probe: merge must catch it.
        @(posedge clk); #1;
        probe_valid_i = 1'b1;
        probe_setid_i = 5'd7;
        probe_tag_i   = 20'h77;
        @(negedge clk);
        check("merge_probe_ready", 32'(probe_ready_o), 32'd1);
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 20'h0});
        @(posedge clk); #1;
        probe_valid_i = 1'b0;
        alloc_valid_i = 1'b1;
        alloc_setid_i = 5'd7;
        alloc_way_i   = 1'b0;
        alloc_tag_i   = 20'h77;
        @(posedge clk); #1;
        alloc_valid_i = 1'b0;
        probe(5'd7, 20'h77, 1'b1, 1'b0, 1'b0, 20'h0);
        probe(5'd7, 20'h55, 1'b0, 1'b1, 1'b0, 20'h0);

        // Probe and alloc to the same set in one cycle: SRAM bypass returns new data.
        @(posedge clk); #1;
        probe_valid_i = 1'b1;
        probe_setid_i = 5'd9;
        probe_tag_i   = 20'h99;
        alloc_valid_i = 1'b1;
        alloc_setid_i = 5'd9;
        alloc_way_i   = 1'b1;
        alloc_tag_i   = 20'h99;
        @(negedge clk);
        check("collide_probe_ready", 32'(probe_ready_o), 32'd1);
        check("collide_alloc_ready", 32'(alloc_ready_o), 32'd1);
        exp_q.push_back('{1'b1, 1'b1, 1'b0, 20'h0});
        @(posedge clk); #1;
        probe_valid_i = 1'b0;
        alloc_valid_i = 1'b0;
        drain(20);

        // Backpressure: only two probes fit in flight.
        stream_set[0] = 5'd3;  stream_tag[0] = 20'hABCDE; stream_exp[0] = '{1'b1, 1'b1, 1'b0, 20'h0};
        stream_set[1] = 5'd5;  stream_tag[1] = 20'h3;     stream_exp[1] = '{1'b1, 1'b0, 1'b0, 20'h0};
        stream_set[2] = 5'd11; stream_tag[2] = 20'hB;     stream_exp[2] = '{1'b1, 1'b1, 1'b0, 20'h0};
        stream_set[3] = 5'd7;  stream_tag[3] = 20'h77;    stream_exp[3] = '{1'b1, 1'b0, 1'b0, 20'h0};
        result_ready_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            probe_valid_i = 1'b1;
            probe_setid_i = stream_set[n_acc];
            probe_tag_i   = stream_tag[n_acc];
            @(negedge clk);
            if (probe_ready_o) begin
                exp_q.push_back(stream_exp[n_acc]);
                n_acc++;
            end
        end
        check("stream_accepted", 32'(n_acc), 32'd2);
        check("stream_ready_held", 32'(probe_ready_o), 32'd0);
        @(posedge clk); #1;
        probe_valid_i  = 1'b0;
        result_ready_i = 1'b1;
        drain(20);
        check("stream_ready_back", 32'(probe_ready_o), 32'd1);

        // Second sweep from IDLE wipes tags and round-robin state.
        @(posedge clk); #1;
        flush_req_i = 1'b1;
        @(posedge clk); #1;
        flush_req_i = 1'b0;
        for (int i = 0; i < 100 && flush_done_cnt < 2; i++) @(negedge clk);
        check("flush2_done_pulses", 32'(flush_done_cnt), 32'd2);
        check("flush2_write_count", 32'(flush_wr_cnt), 32'd64);
        probe(5'd3, 20'hABCDE, 1'b0, 1'b0, 1'b0, 20'h0);
        probe(5'd5, 20'h9, 1'b0, 1'b0, 1'b0, 20'h0);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
